instr_fetch_assembler: RTL and testbench

//  Reads 32-bit RV32I instruction words out of the byte-wide instruction memory on behalf of the core.

---
 rtl/instr_fetch_assembler.sv | 105 ++++++++++
 tb/tb_instr_fetch_assembler.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch_assembler.sv
// Byte-serial instruction fetch: reads four little-endian bytes from the
// instruction memory, assembles the RV32I word and hands it to decode.
module instr_fetch_assembler #(
    parameter int ADDR_WIDTH = 32,
    parameter int OFFSET     = 4
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  flush,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [ADDR_WIDTH-1:0] req_pc,
    output logic                  mem_rd_en,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    input  logic [7:0]            mem_rdata,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [31:0]           rsp_instr,
    output logic [ADDR_WIDTH-1:0] rsp_pc,
    output logic                  rsp_err
);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        LAST,
        RESP
    } state_t;

    localparam logic [ADDR_WIDTH-1:0] OFF = ADDR_WIDTH'(OFFSET);

    state_t     state;
    state_t     state_nxt;
    logic [1:0] k;
    logic [1:0] cap_k;
    logic       cap_en;
    logic       accept;
    logic       misaligned;

    assign misaligned = (req_pc[1:0] != 2'b00);
    assign req_ready  = (state == IDLE) && !flush;
    assign accept     = req_valid && req_ready;
    assign mem_rd_en  = (state == ISSUE);
    assign rsp_valid  = (state == RESP);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        if (flush) begin
            state_nxt = IDLE;
        end else begin
            unique case (state)
                IDLE:  if (accept) state_nxt = misaligned ? RESP : ISSUE;
                ISSUE: if (k == 2'd3) state_nxt = LAST;
                LAST:  state_nxt = RESP;
                RESP:  if (rsp_ready) state_nxt = IDLE;
                default: state_nxt = IDLE;
            endcase
        end
    end

    // Memory returns data one cycle after the strobe, so the byte
    // index travels with a one-cycle delayed capture enable.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            k         <= 2'd0;
            cap_k     <= 2'd0;
            cap_en    <= 1'b0;
            mem_addr  <= '0;
            rsp_instr <= 32'd0;
            rsp_pc    <= '0;
            rsp_err   <= 1'b0;
        end else begin
            cap_en <= mem_rd_en && !flush;
            cap_k  <= k;
            if (flush) begin
                k <= 2'd0;
            end else if (accept) begin
                k         <= 2'd0;
                rsp_pc    <= req_pc;
                rsp_err   <= misaligned;
                rsp_instr <= 32'd0;
                if (!misaligned) begin
                    mem_addr <= req_pc + OFF;
                end
            end else if (state == ISSUE) begin
                k <= k + 2'd1;
                if (k != 2'd3) begin
                    mem_addr <= mem_addr + ADDR_WIDTH'(1);
                end
            end
            if (cap_en && !flush) begin
                rsp_instr[{cap_k, 3'b000} +: 8] <= mem_rdata;
            end
        end
    end

endmodule

// File: tb/tb_instr_fetch_assembler.sv
// Directed bench for instr_fetch_assembler with a byte memory model
// and a response scoreboard.
module tb_instr_fetch_assembler;

    logic        clock = 1'b0;
    logic        reset_n;
    logic        flush;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_pc;
    logic        mem_rd_en;
    logic [31:0] mem_addr;
    logic [7:0]  mem_rdata;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_instr;
    logic [31:0] rsp_pc;
    logic        rsp_err;

    typedef struct {
        logic [31:0] instr;
        logic [31:0] pc;
        logic        err;
    } exp_t;

    exp_t        sb[$];
    logic [7:0]  mem [0:255];
    logic [31:0] prog [0:3];
    int          total = 0;
    int          bad = 0;
    int          cyc = 0;
    int          last_acc = -1;

    instr_fetch_assembler #(
        .ADDR_WIDTH(32),
        .OFFSET(4)
    ) dut (
        .clock(clock),
        .reset_n(reset_n),
        .flush(flush),
        .req_valid(req_valid),
        .req_ready(req_ready),
        .req_pc(req_pc),
        .mem_rd_en(mem_rd_en),
        .mem_addr(mem_addr),
        .mem_rdata(mem_rdata),
        .rsp_valid(rsp_valid),
        .rsp_ready(rsp_ready),
        .rsp_instr(rsp_instr),
        .rsp_pc(rsp_pc),
        .rsp_err(rsp_err)
    );

    always #5 clock = ~clock;

    always @(posedge clock) begin
        cyc <= cyc + 1;
        if (mem_rd_en) begin
            mem_rdata <= mem[mem_addr[7:0]];
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] exp_word(input logic [31:0] pc);
        logic [31:0] a;
        a = pc + 32'd4;
        return {mem[a[7:0] + 8'd3], mem[a[7:0] + 8'd2],
                mem[a[7:0] + 8'd1], mem[a[7:0]]};
    endfunction

    task automatic fetch(input logic [31:0] pc, input int hold,
                         input bit b2b);
        exp_t e;
        int   n;
        int   reads;
        check("req_ready_idle", 32'(req_ready), 32'd1);
        e.pc    = pc;
        e.err   = (pc[1:0] != 2'b00);
        e.instr = e.err ? 32'd0 : exp_word(pc);
        sb.push_back(e);
        rsp_ready = 1'b0;
        req_valid = 1'b1;
        req_pc    = pc;
        tick();
        req_valid = 1'b0;
        if (b2b) begin
            check("accept_gap_ge6", 32'(cyc - last_acc >= 6), 32'd1);
        end
        last_acc = cyc;
        n     = 0;
        reads = 0;
        while (!rsp_valid && n < 20) begin
            if (mem_rd_en) begin
                check("mem_addr", mem_addr, pc + 32'd4 + 32'(reads));
                reads++;
            end
            tick();
            n++;
        end
        check("latency", 32'(n), e.err ? 32'd0 : 32'd5);
        check("reads", 32'(reads), e.err ? 32'd0 : 32'd4);
        for (int i = 0; i < hold; i++) begin
            check("hold_valid", 32'(rsp_valid), 32'd1);
            check("hold_instr", rsp_instr, e.instr);
            check("hold_pc", rsp_pc, e.pc);
            check("hold_req_ready", 32'(req_ready), 32'd0);
            check("hold_rd_en", 32'(mem_rd_en), 32'd0);
            tick();
        end
        rsp_ready = 1'b1;
        if (sb.size() > 0) begin
            e = sb.pop_front();
        end
        check("rsp_valid", 32'(rsp_valid), 32'd1);
        check("rsp_instr", rsp_instr, e.instr);
        check("rsp_pc", rsp_pc, e.pc);
        check("rsp_err", 32'(rsp_err), 32'(e.err));
        check("rsp_req_ready", 32'(req_ready), 32'd0);
        tick();
        rsp_ready = 1'b0;
        check("released", 32'(rsp_valid), 32'd0);
    endtask

    initial begin
        reset_n   = 1'b0;
        flush     = 1'b0;
        req_valid = 1'b0;
        req_pc    = 32'd0;
        rsp_ready = 1'b0;
        prog[0] = 32'h00a00293;
        prog[1] = 32'h06500313;
        prog[2] = 32'h0062a023;
        prog[3] = 32'h0002af83;
        for (int i = 0; i < 256; i++) mem[i] = 8'h00;
        for (int j = 0; j < 4; j++) begin
            for (int b = 0; b < 4; b++) begin
                mem[4 + 4*j + b] = prog[j][8*b +: 8];
            end
        end
        mem[0] = 8'hb7;
        mem[1] = 8'h50;
        mem[2] = 8'h34;
        mem[3] = 8'h12;

        repeat (2) tick();
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_rd_en", 32'(mem_rd_en), 32'd0);
        check("rst_mem_addr", mem_addr, 32'd0);
        check("rst_instr", rsp_instr, 32'd0);
        check("rst_pc", rsp_pc, 32'd0);
        check("rst_err", 32'(rsp_err), 32'd0);
        reset_n = 1'b1;
        tick();

        fetch(32'd0, 0, 1'b0);
        check("word0", rsp_instr, 32'h00a00293);

        fetch(32'd0, 0, 1'b0);
        fetch(32'd4, 0, 1'b1);
        fetch(32'd8, 0, 1'b1);
        fetch(32'd12, 0, 1'b1);

        fetch(32'd8, 3, 1'b0);

        fetch(32'd2, 0, 1'b0);

        req_valid = 1'b1;
        req_pc    = 32'd4;
        tick();
        req_valid = 1'b0;
        tick();
        tick();
        check("flush_k2_addr", mem_addr, 32'd10);
        flush     = 1'b1;
        req_valid = 1'b1;
        #1;
        check("flush_req_ready", 32'(req_ready), 32'd0);
        tick();
        flush     = 1'b0;
        req_valid = 1'b0;
        check("flush_rd_en", 32'(mem_rd_en), 32'd0);
        check("flush_rsp_valid", 32'(rsp_valid), 32'd0);
        #1;
        check("flush_idle", 32'(req_ready), 32'd1);
        for (int i = 0; i < 6; i++) begin
            tick();
            check("flush_no_rsp", 32'(rsp_valid), 32'd0);
        end
        fetch(32'd4, 0, 1'b0);

        flush     = 1'b1;
        req_valid = 1'b1;
        req_pc    = 32'd0;
        tick();
        flush     = 1'b0;
        req_valid = 1'b0;
        check("flush_beats_req", 32'(mem_rd_en), 32'd0);

        req_valid = 1'b1;
        req_pc    = 32'd6;
        tick();
        req_valid = 1'b0;
        check("mis_rsp_valid", 32'(rsp_valid), 32'd1);
        rsp_ready = 1'b1;
        flush     = 1'b1;
        tick();
        flush     = 1'b0;
        rsp_ready = 1'b0;
        check("flush_resp_drop", 32'(rsp_valid), 32'd0);

        req_valid = 1'b1;
        req_pc    = 32'd4;
        tick();
        req_valid = 1'b0;
        tick();
        reset_n = 1'b0;
        #1;
        check("mrst_rd_en", 32'(mem_rd_en), 32'd0);
        check("mrst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("mrst_mem_addr", mem_addr, 32'd0);
        check("mrst_instr", rsp_instr, 32'd0);
        tick();
        reset_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
            check("mrst_no_rsp", 32'(rsp_valid), 32'd0);
        end
        fetch(32'd4, 0, 1'b0);

        fetch(32'hFFFFFFFC, 0, 1'b0);
        check("wrap_word", rsp_instr, 32'h123450b7);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
